// File: rtl/vga_char_feeder_if.sv
// CPU-side and display-side signals of the character feeder, bundled as one bus.
// The feeder takes the master view; the CPU/display environment takes the slave view.
interface vga_char_feeder_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  cpu_we;
    logic [7:0]            cpu_data;
    logic                  flush;
    logic                  cpu_ready;
    logic                  overflow;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  dsp_address;
    logic                  dsp_enable;
    logic                  dsp_w_en;
    logic [7:0]            dsp_din;

    modport master (
        input  cpu_we, cpu_data, flush,
        output cpu_ready, overflow, fifo_count,
        output dsp_address, dsp_enable, dsp_w_en, dsp_din
    );

    modport slave (
        output cpu_we, cpu_data, flush,
        input  cpu_ready, overflow, fifo_count,
        input  dsp_address, dsp_enable, dsp_w_en, dsp_din
    );
endinterface

// File: rtl/vga_char_feeder.sv
// Queues CPU character writes and replays them onto the text display bus as
// SETUP / STROBE / RELEASE (/ PACE) cycles with registered outputs.
module vga_char_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int HOLD_CYC   = 2,
    parameter int GAP_CYC    = 2,
    parameter int PACE_DIV   = 0
) (
    input  logic               clk25,
    input  logic               rst,
    vga_char_feeder_if.master  bus
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_HG > PACE_DIV) ? MAX_HG : PACE_DIV;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0]       HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]       GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0]       PACE_LD  = CW'((PACE_DIV > 0) ? PACE_DIV - 1 : 0);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_PACE
    } state_t;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, count;
    logic                full, empty, push, pop, ovf_q;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                address_q, address_d;
    logic                enable_q, enable_d;
    logic [7:0]          din_q;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (wr_ptr == rd_ptr);
    // flush beats both a concurrent write and the pop of a new head byte
    assign push  = bus.cpu_we && !full && !bus.flush;
    assign pop   = (state_q == S_IDLE) && !empty && !bus.flush;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (bus.cpu_we && full)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk25) begin
        if (push)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.cpu_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:
                if (!empty)
                    state_d = S_SETUP;
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = HOLD_LD;
            end
            S_STROBE:
                if (cnt_q == '0) begin
                    state_d = S_RELEASE;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            S_RELEASE:
                if (cnt_q == '0) begin
                    if (PACE_DIV > 0) begin
                        state_d = S_PACE;
                        cnt_d   = PACE_LD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            S_PACE:
                if (cnt_q == '0)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q - 1'b1;
            default:
                state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
        // Outputs follow the next state so they are registered with it;
        // address stays low through RELEASE so the display re-arms its latch.
        address_d = !(state_d inside {S_SETUP, S_STROBE, S_RELEASE});
        enable_d  = (state_d == S_STROBE);
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            address_q <= 1'b1;
            enable_q  <= 1'b0;
            din_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            address_q <= address_d;
            enable_q  <= enable_d;
            if (pop)
                din_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    assign bus.cpu_ready   = !full;
    assign bus.overflow    = ovf_q;
    assign bus.fifo_count  = count;
    assign bus.dsp_address = address_q;
    assign bus.dsp_enable  = enable_q;
    assign bus.dsp_w_en    = enable_q;
    assign bus.dsp_din     = din_q;
endmodule

// File: tb/tb_vga_char_feeder.sv
// Directed bench for vga_char_feeder: one unthrottled instance and one with PACE_DIV=10,
// strobe monitors on both display buses and a tiny 40x24 display model for the text check.
module tb_vga_char_feeder;
    logic clk25 = 1'b0;
    logic rst;
    always #5 clk25 = ~clk25;

    vga_char_feeder_if #(.DEPTH_LOG2(4)) bus0 ();
    vga_char_feeder_if #(.DEPTH_LOG2(4)) bus1 ();

    vga_char_feeder #(.DEPTH_LOG2(4), .HOLD_CYC(2), .GAP_CYC(2), .PACE_DIV(0)) u0 (
        .clk25 (clk25),
        .rst   (rst),
        .bus   (bus0.master)
    );

    vga_char_feeder #(.DEPTH_LOG2(4), .HOLD_CYC(2), .GAP_CYC(2), .PACE_DIV(10)) u1 (
        .clk25 (clk25),
        .rst   (rst),
        .bus   (bus1.master)
    );

    int total  = 0;
    int passed = 0;

    // Strobe monitors: record din and cycle number at each rising edge of enable.
    int         cyc = 0;
    logic       en_prev0 = 1'b0, en_prev1 = 1'b0;
    logic [7:0] q0_din [$];
    int         q0_cyc [$];
    logic [7:0] q1_din [$];
    int         q1_cyc [$];
    int         bad0 = 0;

    always @(posedge clk25) cyc <= cyc + 1;

    always @(negedge clk25) begin
        if (bus0.dsp_enable === 1'b1 && en_prev0 !== 1'b1) begin
            q0_din.push_back(bus0.dsp_din);
            q0_cyc.push_back(cyc);
        end
        if ((bus0.dsp_enable === 1'b1 && bus0.dsp_address !== 1'b0) ||
            (bus0.dsp_w_en !== bus0.dsp_enable))
            bad0 <= bad0 + 1;
        en_prev0 <= bus0.dsp_enable;
        if (bus1.dsp_enable === 1'b1 && en_prev1 !== 1'b1) begin
            q1_din.push_back(bus1.dsp_din);
            q1_cyc.push_back(cyc);
        end
        en_prev1 <= bus1.dsp_enable;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic wait_q0(input int n, input string tag);
        int budget;
        budget = 400;
        while (q0_din.size() < n && budget > 0) begin
            step();
            budget--;
        end
        chk(tag, 32'(q0_din.size() >= n), 1);
    endtask

    task automatic push0(input logic [7:0] b);
        bus0.cpu_we   = 1'b1;
        bus0.cpu_data = b;
        step();
        bus0.cpu_we   = 1'b0;
    endtask

    int         base, row, col;
    logic [7:0] cells [0:959];

    initial begin
        rst = 1'b1;
        bus0.cpu_we = 1'b0; bus0.cpu_data = 8'h00; bus0.flush = 1'b0;
        bus1.cpu_we = 1'b0; bus1.cpu_data = 8'h00; bus1.flush = 1'b0;
        repeat (2) @(posedge clk25);
        #1;
        chk("rst_count",   bus0.fifo_count, 0);
        chk("rst_ready",   bus0.cpu_ready, 1);
        chk("rst_ovf",     bus0.overflow, 0);
        chk("rst_addr",    bus0.dsp_address, 1);
        chk("rst_en",      bus0.dsp_enable, 0);
        chk("rst_wen",     bus0.dsp_w_en, 0);
        chk("rst_din",     bus0.dsp_din, 8'h00);
        rst = 1'b0;
        step();

        // Single character C1
        base = q0_din.size();
        push0(8'hC1);
        chk("t1_cnt1", bus0.fifo_count, 1);
        chk("t1_idle_addr", bus0.dsp_address, 1);
        step();
        chk("t1_setup_addr", bus0.dsp_address, 0);
        chk("t1_setup_en", bus0.dsp_enable, 0);
        chk("t1_setup_din", bus0.dsp_din, 8'hC1);
        chk("t1_cnt0", bus0.fifo_count, 0);
        step();
        chk("t1_strobe1_en", bus0.dsp_enable, 1);
        chk("t1_strobe1_wen", bus0.dsp_w_en, 1);
        chk("t1_strobe1_addr", bus0.dsp_address, 0);
        step();
        chk("t1_strobe2_en", bus0.dsp_enable, 1);
        chk("t1_strobe2_din", bus0.dsp_din, 8'hC1);
        step();
        chk("t1_rel1_en", bus0.dsp_enable, 0);
        chk("t1_rel1_addr", bus0.dsp_address, 0);
        step();
        chk("t1_rel2_en", bus0.dsp_enable, 0);
        chk("t1_rel2_addr", bus0.dsp_address, 0);
        step();
        chk("t1_idle_addr2", bus0.dsp_address, 1);
        chk("t1_nstrobes", q0_din.size(), base + 1);

        // Fill to full while the FSM drains at 1 per 6 cycles, then overflow
        base = q0_din.size();
        bus0.cpu_we = 1'b1;
        for (int i = 0; i < 19; i++) begin
            bus0.cpu_data = 8'(i);
            step();
        end
        bus0.cpu_we = 1'b0;
        chk("t2_full_cnt", bus0.fifo_count, 16);
        chk("t2_full_ready", bus0.cpu_ready, 0);
        step();
        chk("t2_after_pop_cnt", bus0.fifo_count, 15);
        chk("t2_after_pop_ready", bus0.cpu_ready, 1);
        push0(8'd19);
        chk("t2_refull_cnt", bus0.fifo_count, 16);
        chk("t2_no_ovf_yet", bus0.overflow, 0);
        push0(8'hEE);
        chk("t2_ovf", bus0.overflow, 1);
        chk("t2_ovf_cnt", bus0.fifo_count, 16);
        wait_q0(base + 20, "t2_wait");
        repeat (10) step();
        chk("t2_nstrobes", q0_din.size(), base + 20);
        for (int i = 0; i < 20 && base + i < q0_din.size(); i++)
            chk($sformatf("t2_byte%0d", i), q0_din[base + i], 8'(i));
        for (int i = 0; i < 19 && base + i + 1 < q0_cyc.size(); i++)
            chk($sformatf("t2_period%0d", i), q0_cyc[base + i + 1] - q0_cyc[base + i], 6);
        chk("t2_drained", bus0.fifo_count, 0);

        // Simultaneous push/pop at count 5, then 40 bytes across pointer wrap
        base = q0_din.size();
        bus0.cpu_we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus0.cpu_data = 8'h80 + 8'(i);
            step();
        end
        bus0.cpu_we = 1'b0;
        chk("t3_cnt5", bus0.fifo_count, 5);
        step();
        chk("t3_cnt5_idle", bus0.fifo_count, 5);
        push0(8'h86);
        chk("t3_pushpop_cnt", bus0.fifo_count, 5);
        for (int i = 7; i < 40; i++) begin
            push0(8'h80 + 8'(i));
            repeat (4) step();
        end
        wait_q0(base + 40, "t3_wait");
        repeat (10) step();
        chk("t3_nstrobes", q0_din.size(), base + 40);
        for (int i = 0; i < 40 && base + i < q0_din.size(); i++)
            chk($sformatf("t3_byte%0d", i), q0_din[base + i], 8'h80 + 8'(i));

        // Flush during STROBE
        chk("t4_ovf_before", bus0.overflow, 1);
        base = q0_din.size();
        bus0.cpu_we = 1'b1;
        bus0.cpu_data = 8'hD0; step();
        bus0.cpu_data = 8'hD1; step();
        bus0.cpu_data = 8'hD2; step();
        bus0.cpu_we = 1'b0;
        chk("t4_in_strobe", bus0.dsp_enable, 1);
        chk("t4_strobe_din", bus0.dsp_din, 8'hD0);
        chk("t4_cnt2", bus0.fifo_count, 2);
        bus0.flush = 1'b1;
        step();
        bus0.flush = 1'b0;
        chk("t4_flush_en", bus0.dsp_enable, 0);
        chk("t4_flush_wen", bus0.dsp_w_en, 0);
        chk("t4_flush_addr", bus0.dsp_address, 1);
        chk("t4_flush_cnt", bus0.fifo_count, 0);
        chk("t4_flush_ovf", bus0.overflow, 0);
        chk("t4_flush_ready", bus0.cpu_ready, 1);
        bus0.flush = 1'b1;
        push0(8'hEE);
        bus0.flush = 1'b0;
        chk("t4_flush_wins_cnt", bus0.fifo_count, 0);
        repeat (20) step();
        chk("t4_no_more_strobes", q0_din.size(), base + 1);

        // PACE_DIV=10 spacing, then async reset during PACE
        bus1.cpu_we = 1'b1;
        bus1.cpu_data = 8'h5A; step();
        bus1.cpu_data = 8'h5B; step();
        bus1.cpu_data = 8'h5C; step();
        bus1.cpu_we = 1'b0;
        repeat (22) step();
        chk("t5_nstrobes", q1_din.size(), 2);
        if (q1_cyc.size() >= 2)
            chk("t5_spacing", q1_cyc[1] - q1_cyc[0], 16);
        chk("t5_pace_addr", bus1.dsp_address, 1);
        chk("t5_pace_en", bus1.dsp_enable, 0);
        chk("t5_pace_din", bus1.dsp_din, 8'h5B);
        chk("t5_pace_cnt", bus1.fifo_count, 1);
        rst = 1'b1;
        #2;
        chk("t5_arst_din", bus1.dsp_din, 8'h00);
        chk("t5_arst_cnt", bus1.fifo_count, 0);
        chk("t5_arst_addr", bus1.dsp_address, 1);
        chk("t5_arst_en", bus1.dsp_enable, 0);
        chk("t5_arst_ready", bus1.cpu_ready, 1);
        @(posedge clk25);
        #1;
        rst = 1'b0;
        step();

        // "HI\r" through a minimal display model
        base = q0_din.size();
        push0(8'h48);
        push0(8'h49);
        push0(8'h0D);
        wait_q0(base + 3, "t6_wait");
        repeat (20) step();
        chk("t6_nstrobes", q0_din.size(), base + 3);
        row = 0;
        col = 0;
        for (int i = base; i < q0_din.size(); i++) begin
            if (q0_din[i] == 8'h0D || q0_din[i] == 8'h8D) begin
                row++;
                col = 0;
            end else begin
                cells[row * 40 + col] = q0_din[i];
                col++;
            end
        end
        chk("t6_cell00", cells[0], 8'h48);
        chk("t6_cell01", cells[1], 8'h49);
        chk("t6_row", row, 1);
        chk("t6_col", col, 0);
        chk("t6_bus_protocol", bad0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
